// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared constants, types and select decoding for the butterfly output crossbar
package bf_pkg;

    localparam logic MODE_R2 = 1'b0;
    localparam logic MODE_R4 = 1'b1;

    localparam int DEF_DLY_R2 = 10;
    localparam int DEF_DLY_R4 = 12;

    // Widest select code any instance may use; instances zero-extend their codes into this.
    localparam int BF_SEL_MAX_W = 8;

    typedef logic [BF_SEL_MAX_W-1:0] bf_sel_t;

    typedef struct packed {
        logic [BF_SEL_MAX_W-2:0] b;
        logic                    upper;
    } bf_src_t;

    // Split a select code into source butterfly index and upper/lower choice.
    function automatic bf_src_t bf_src_idx(input bf_sel_t k);
        bf_src_t s;
        s.b     = k[BF_SEL_MAX_W-1:1];
        s.upper = k[0];
        return s;
    endfunction

endpackage

// File: rtl/bf_sel_delay.sv
// rtl/bf_sel_delay.sv - free-running select delay line with two taps and an any-valid summary
module bf_sel_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int TAP_A = 10,
    parameter int TAP_B = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] entry,
    output logic [WIDTH-1:0] tap_a,
    output logic [WIDTH-1:0] tap_b,
    output logic             any_vld
);

    // Stage k holds the entry accepted k cycles ago; the MSB of each entry is its valid bit.
    logic [WIDTH-1:0] line [1:DEPTH];

    // Shift every cycle; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= DEPTH; i++) line[i] <= '0;
        end else begin
            line[1] <= entry;
            for (int i = 2; i <= DEPTH; i++) line[i] <= line[i-1];
        end
    end

    assign tap_a = line[TAP_A];
    assign tap_b = line[TAP_B];

    // OR of every stage's valid bit.
    always_comb begin
        any_vld = 1'b0;
        for (int i = 1; i <= DEPTH; i++) any_vld = any_vld | line[i][WIDTH-1];
    end

endmodule

// File: rtl/bf_out_xbar.sv
// rtl/bf_out_xbar.sv - butterfly-output crossbar routing NTT results onto memory-write lanes
module bf_out_xbar
    import bf_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_BF     = 2,
    parameter int DLY_R2     = DEF_DLY_R2,
    parameter int DLY_R4     = DEF_DLY_R4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      sel_vld_in,
    input  logic                                      mode_in,
    input  logic [2*NUM_BF*$clog2(2*NUM_BF)-1:0]      sel_in,
    input  logic [NUM_BF*DATA_WIDTH-1:0]              bf_upper,
    input  logic [NUM_BF*DATA_WIDTH-1:0]              bf_lower,
    input  logic                                      err_clr,
    output logic [2*NUM_BF*DATA_WIDTH-1:0]            d_out,
    output logic                                      d_vld,
    output logic                                      busy,
    output logic                                      err_dup,
    output logic                                      err_col
);

    localparam int N      = 2 * NUM_BF;
    localparam int SEL_W  = $clog2(N);
    localparam int EW     = 2 + N * SEL_W;
    localparam int BIDX_W = (NUM_BF > 1) ? $clog2(NUM_BF) : 1;

    logic [EW-1:0]         tap_r2;
    logic [EW-1:0]         tap_r4;
    logic                  r2_hit;
    logic                  r4_hit;
    logic                  beat;
    logic [N*SEL_W-1:0]    route_sel;
    logic [DATA_WIDTH-1:0] upper_arr [NUM_BF];
    logic [DATA_WIDTH-1:0] lower_arr [NUM_BF];
    logic [N*DATA_WIDTH-1:0] lane_flat;
    logic [N-1:0]          lane_bad;
    logic                  dup_any;

    // One shared line carries {vld, mode, sel}; the mode bit decides which tap claims an entry.
    bf_sel_delay #(
        .WIDTH (EW),
        .DEPTH (DLY_R4),
        .TAP_A (DLY_R2),
        .TAP_B (DLY_R4)
    ) u_sel_delay (
        .clk     (clk),
        .rst     (rst),
        .entry   ({sel_vld_in, mode_in, sel_in}),
        .tap_a   (tap_r2),
        .tap_b   (tap_r4),
        .any_vld (busy)
    );

    assign r2_hit = tap_r2[EW-1] && (tap_r2[EW-2] == MODE_R2);
    assign r4_hit = tap_r4[EW-1] && (tap_r4[EW-2] == MODE_R4);
    assign beat   = r2_hit || r4_hit;

    // The radix-4 entry is older, so it wins a collision and the radix-2 entry is dropped.
    assign route_sel = r4_hit ? tap_r4[N*SEL_W-1:0] : tap_r2[N*SEL_W-1:0];

    genvar gb, gl;
    generate
        for (gb = 0; gb < NUM_BF; gb++) begin : g_unpack
            assign upper_arr[gb] = bf_upper[gb*DATA_WIDTH +: DATA_WIDTH];
            assign lower_arr[gb] = bf_lower[gb*DATA_WIDTH +: DATA_WIDTH];
        end

        for (gl = 0; gl < N; gl++) begin : g_lane
            logic [SEL_W-1:0]  code;
            bf_src_t           src;
            logic              legal;
            logic [BIDX_W-1:0] bidx;

            assign code  = route_sel[gl*SEL_W +: SEL_W];
            assign src   = bf_src_idx(bf_sel_t'(code));
            assign legal = (src.b < (BF_SEL_MAX_W-1)'(NUM_BF));
            assign bidx  = src.b[BIDX_W-1:0];

            // Illegal codes drive the lane to zero and are flagged as duplicates.
            assign lane_flat[gl*DATA_WIDTH +: DATA_WIDTH] =
                !legal ? '0 : (src.upper ? upper_arr[bidx] : lower_arr[bidx]);
            assign lane_bad[gl] = !legal;
        end
    endgenerate

    // Pairwise compare of lane select codes, plus any illegal code.
    always_comb begin
        dup_any = |lane_bad;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (route_sel[i*SEL_W +: SEL_W] == route_sel[j*SEL_W +: SEL_W]) dup_any = 1'b1;
            end
        end
    end

    // Registered outputs; d_out holds between beats and error flags are sticky with set priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out   <= '0;
            d_vld   <= 1'b0;
            err_dup <= 1'b0;
            err_col <= 1'b0;
        end else begin
            d_vld <= beat;
            if (beat) d_out <= lane_flat;

            if (beat && dup_any)   err_dup <= 1'b1;
            else if (err_clr)      err_dup <= 1'b0;

            if (r2_hit && r4_hit)  err_col <= 1'b1;
            else if (err_clr)      err_col <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bf_out_xbar.sv
// tb/tb_bf_out_xbar.sv - scoreboard bench for bf_out_xbar against a cycle-indexed reference model
module tb_bf_out_xbar;

    localparam int DW = 12;
    localparam int NB = 2;
    localparam int NL = 2 * NB;
    localparam int SW = 2;
    localparam int D2 = 10;
    localparam int D4 = 12;
    localparam int MAXC = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic            sel_vld_in;
    logic            mode_in;
    logic [NL*SW-1:0] sel_in;
    logic [NB*DW-1:0] bf_upper;
    logic [NB*DW-1:0] bf_lower;
    logic            err_clr;
    logic [NL*DW-1:0] d_out;
    logic            d_vld;
    logic            busy;
    logic            err_dup;
    logic            err_col;

    bf_out_xbar #(
        .DATA_WIDTH (DW),
        .NUM_BF     (NB),
        .DLY_R2     (D2),
        .DLY_R4     (D4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_vld_in (sel_vld_in),
        .mode_in    (mode_in),
        .sel_in     (sel_in),
        .bf_upper   (bf_upper),
        .bf_lower   (bf_lower),
        .err_clr    (err_clr),
        .d_out      (d_out),
        .d_vld      (d_vld),
        .busy       (busy),
        .err_dup    (err_dup),
        .err_col    (err_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              mat;
        bit              mode;
        logic [NL*SW-1:0] sel;
    } pend_t;

    typedef struct {
        int              cyc;
        logic [NL*DW-1:0] data;
    } beat_t;

    pend_t pend[$];
    beat_t sbq[$];

    logic [NL*DW-1:0] exp_dout [0:MAXC-1];
    bit               exp_busy [0:MAXC-1];
    bit               exp_dup  [0:MAXC-1];
    bit               exp_col  [0:MAXC-1];
    bit               issued   [0:MAXC-1];

    int  cyc = 0;
    int  last_rst = -1;
    bit  mon_on = 1'b0;
    bit  m_dup, m_col;
    logic [NL*DW-1:0] m_dout;
    int  n_checks = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Lane j takes butterfly k/2, upper half when k is odd, zero when k names no butterfly.
    function automatic logic [NL*DW-1:0] ref_route(input logic [NL*SW-1:0] sel,
                                                    input logic [NB*DW-1:0] up,
                                                    input logic [NB*DW-1:0] lo);
        logic [NL*DW-1:0] r = '0;
        for (int j = 0; j < NL; j++) begin
            int k = int'(sel[j*SW +: SW]);
            int b = k / 2;
            if (k >= 2 * NB)   r[j*DW +: DW] = '0;
            else if (k % 2)    r[j*DW +: DW] = up[b*DW +: DW];
            else               r[j*DW +: DW] = lo[b*DW +: DW];
        end
        return r;
    endfunction

    function automatic bit ref_dup(input logic [NL*SW-1:0] sel);
        bit d = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (int'(sel[i*SW +: SW]) >= 2 * NB) d = 1'b1;
            for (int j = i + 1; j < NL; j++)
                if (sel[i*SW +: SW] == sel[j*SW +: SW]) d = 1'b1;
        end
        return d;
    endfunction

    // Reference model: every select matures DLY_mode cycles after issue; expectations land at c+1.
    task automatic model();
        int c = cyc;
        int i2 = -1;
        int i4 = -1;
        bit dup_set = 1'b0;
        bit col_set = 1'b0;
        bit b = 1'b0;
        logic [NL*SW-1:0] s;
        if (rst) begin
            pend.delete();
            last_rst = c;
            m_dout = '0;
            m_dup = 1'b0;
            m_col = 1'b0;
        end else begin
            if (sel_vld_in) begin
                pend.push_back('{c + (mode_in ? D4 : D2), mode_in, sel_in});
                issued[c] = 1'b1;
            end
            foreach (pend[i]) begin
                if (pend[i].mat == c) begin
                    if (pend[i].mode) i4 = i;
                    else              i2 = i;
                end
            end
            if (i4 >= 0 || i2 >= 0) begin
                s = (i4 >= 0) ? pend[i4].sel : pend[i2].sel;
                m_dout = ref_route(s, bf_upper, bf_lower);
                dup_set = ref_dup(s);
                sbq.push_back('{c + 1, m_dout});
            end
            col_set = (i4 >= 0) && (i2 >= 0);
            m_dup = dup_set | (m_dup & !err_clr);
            m_col = col_set | (m_col & !err_clr);
            for (int i = pend.size() - 1; i >= 0; i--)
                if (pend[i].mat == c) pend.delete(i);
        end
        for (int t = c - D4 + 1; t <= c; t++)
            if (t >= 0 && t > last_rst && issued[t]) b = 1'b1;
        exp_busy[c+1] = b;
        exp_dout[c+1] = m_dout;
        exp_dup[c+1]  = m_dup;
        exp_col[c+1]  = m_col;
    endtask

    task automatic rand_data();
        bf_upper = (NB*DW)'($urandom);
        bf_lower = (NB*DW)'($urandom);
    endtask

    task automatic tick();
        model();
        @(posedge clk);
        #1;
        cyc++;
        mon_on = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sel_vld_in = 1'b0;
            rand_data();
            tick();
        end
    endtask

    task automatic issue(input bit m, input logic [NL*SW-1:0] s);
        sel_vld_in = 1'b1;
        mode_in = m;
        sel_in = s;
        rand_data();
        tick();
        sel_vld_in = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        rand_data();
        tick();
        err_clr = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a beat is due and checks the held state every cycle.
    always @(negedge clk) begin : mon
        beat_t bt;
        bit ev;
        if (mon_on) begin
            ev = (sbq.size() > 0) && (sbq[0].cyc == cyc);
            chk("d_vld", {63'd0, d_vld}, {63'd0, ev});
            if (ev) begin
                bt = sbq.pop_front();
                chk("beat_data", 64'(d_out), 64'(bt.data));
            end
            chk("d_out_hold", 64'(d_out), 64'(exp_dout[cyc]));
            chk("busy", {63'd0, busy}, {63'd0, exp_busy[cyc]});
            chk("err_dup", {63'd0, err_dup}, {63'd0, exp_dup[cyc]});
            chk("err_col", {63'd0, err_col}, {63'd0, exp_col[cyc]});
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        sel_vld_in = 1'b0;
        mode_in = 1'b0;
        sel_in = '0;
        err_clr = 1'b0;
        rand_data();
        for (int i = 0; i < MAXC; i++) issued[i] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_d_out", 64'(d_out), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        idle(2);

        // Radix-2 identity
        issue(1'b0, 8'he4);
        idle(9);
        bf_lower = {12'h033, 12'h011};
        bf_upper = {12'h044, 12'h022};
        tick();
        chk("t1_vld", {63'd0, d_vld}, 64'd1);
        chk("t1_lanes", 64'(d_out), 64'h044033022011);
        chk("t1_dup", {63'd0, err_dup}, 64'd0);
        idle(15);

        // Radix-4 latency
        issue(1'b1, 8'he4);
        idle(10);
        chk("t2_no_early", {63'd0, d_vld}, 64'd0);
        idle(1);
        bf_lower = {12'h0a3, 12'h0a1};
        bf_upper = {12'h0a4, 12'h0a2};
        tick();
        chk("t2_vld", {63'd0, d_vld}, 64'd1);
        chk("t2_lanes", 64'(d_out), 64'h0a40a30a20a1);
        chk("t2_busy_low", {63'd0, busy}, 64'd0);
        idle(15);

        // Mode collision
        issue(1'b1, 8'h1b);
        idle(1);
        issue(1'b0, 8'he4);
        idle(10);
        chk("t3_col", {63'd0, err_col}, 64'd1);
        pulse_clr();
        chk("t3_col_clr", {63'd0, err_col}, 64'd0);
        idle(15);

        // Duplicate select
        issue(1'b0, 8'h52);
        idle(10);
        chk("t4_dup", {63'd0, err_dup}, 64'd1);
        pulse_clr();
        chk("t4_dup_clr", {63'd0, err_dup}, 64'd0);
        idle(15);

        // Back-to-back radix-2 stream
        for (int i = 0; i < 20; i++) issue(1'b0, 8'($urandom));
        idle(15);

        // Random mix of modes, clears and occasional resets
        for (int i = 0; i < 300; i++) begin
            sel_vld_in = ($urandom_range(0, 1) == 1);
            mode_in = ($urandom_range(0, 1) == 1);
            sel_in = 8'($urandom);
            err_clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 79) == 0);
            rand_data();
            tick();
        end
        rst = 1'b0;
        err_clr = 1'b0;
        sel_vld_in = 1'b0;
        idle(15);

        // Reset mid-operation
        issue(1'b0, 8'h00);
        issue(1'b0, 8'he4);
        issue(1'b1, 8'h1b);
        issue(1'b0, 8'h4e);
        rst = 1'b1;
        issue(1'b1, 8'he4);
        rst = 1'b0;
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_d_out", 64'(d_out), 64'd0);
        chk("t6_d_vld", {63'd0, d_vld}, 64'd0);
        chk("t6_flags", {62'd0, err_dup, err_col}, 64'd0);
        idle(20);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
